// File: rtl/pixel_packet_serializer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pixel_packet_serializer                                                  |
// | Packs a header, a run of BRAM pixels and audio bytes into LSB-first      |
// | dibits.                                                                  |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module pixel_packet_serializer #(
  parameter int ADDR_BYTES     = 3,
  parameter int PIXELS_PER_PKT = 320,
  parameter int AUDIO_BYTES    = 4,
  parameter int FRAME_PIXELS   = 76800,
  parameter int BRAM_LATENCY   = 2,
  parameter int GAP_CYCLES     = 12
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    stall,
  input  logic [7:0]              pixel,
  input  logic [7:0]              audio,
  input  logic                    audio_valid,
  output logic                    audio_ready,
  output logic                    axiov,
  output logic [1:0]              axiod,
  output logic [8*ADDR_BYTES-1:0] pixel_addr,
  output logic                    pkt_done,
  output logic                    audio_underrun
);

  localparam int c_aw      = 8 * ADDR_BYTES;
  localparam int c_hdr_len = 4 * ADDR_BYTES;
  localparam int c_pix_len = 4 * PIXELS_PER_PKT;
  localparam int c_aud_len = 4 * AUDIO_BYTES;
  localparam int c_m1      = (c_hdr_len > c_pix_len) ? c_hdr_len : c_pix_len;
  localparam int c_m2      = (c_m1 > c_aud_len) ? c_m1 : c_aud_len;
  localparam int c_cnt_max = (c_m2 > GAP_CYCLES) ? c_m2 : GAP_CYCLES;
  localparam int c_cw      = $clog2(c_cnt_max + 1);
  localparam int c_hw      = c_cw - 2;

  localparam logic [c_cw-1:0] c_hdr_last  = c_cw'(c_hdr_len - 1);
  localparam logic [c_cw-1:0] c_pix_last  = c_cw'(c_pix_len - 1);
  localparam logic [c_cw-1:0] c_aud_last  = c_cw'((c_aud_len > 0) ? c_aud_len - 1 : 0);
  localparam logic [c_cw-1:0] c_gap_last  = c_cw'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  // Slot phase at which the next pixel's address is launched so it has
  // exactly BRAM_LATENCY cycles to settle before the slot-0 load edge.
  localparam logic [1:0]      c_adv_phase = 2'((4 - BRAM_LATENCY) % 4);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_PIXEL = 3'd2,
    S_AUDIO = 3'd3,
    S_GAP   = 3'd4
  } state_t;

  state_t            r_state, w_state;
  logic [c_cw-1:0]   r_cnt, w_cnt;
  logic              r_run;
  logic [c_aw-1:0]   r_pkt_start, w_pkt_start;
  logic [c_aw-1:0]   w_pixel_addr, w_addr_inc;
  logic [5:0]        r_shift, w_shift;
  logic [7:0]        w_byte;
  logic [1:0]        w_axiod;
  logic              w_axiov, w_pkt_done, w_audio_ready, w_audio_underrun;
  logic              w_unfinished;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_cnt          <= '0;
      r_run          <= 1'b0;
      r_pkt_start    <= '0;
      r_shift        <= '0;
      axiov          <= 1'b0;
      axiod          <= 2'b00;
      pixel_addr     <= '0;
      pkt_done       <= 1'b0;
      audio_ready    <= 1'b0;
      audio_underrun <= 1'b0;
    end else begin
      r_state        <= w_state;
      r_cnt          <= w_cnt;
      r_run          <= 1'b1;
      r_pkt_start    <= w_pkt_start;
      r_shift        <= w_shift;
      axiov          <= w_axiov;
      axiod          <= w_axiod;
      pixel_addr     <= w_pixel_addr;
      pkt_done       <= w_pkt_done;
      audio_ready    <= w_audio_ready;
      audio_underrun <= w_audio_underrun;
    end
  end

  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt + 1'b1;
    if (stall) begin
      w_state = S_IDLE;
      w_cnt   = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_cnt = '0;
          if (r_run) w_state = S_ADDR;
        end
        S_ADDR: begin
          if (r_cnt == c_hdr_last) begin
            w_state = S_PIXEL;
            w_cnt   = '0;
          end
        end
        S_PIXEL: begin
          if (r_cnt == c_pix_last) begin
            w_state = (AUDIO_BYTES > 0) ? S_AUDIO : S_GAP;
            w_cnt   = '0;
          end
        end
        S_AUDIO: begin
          if (r_cnt == c_aud_last) begin
            w_state = S_GAP;
            w_cnt   = '0;
          end
        end
        S_GAP: begin
          if (r_cnt == c_gap_last) begin
            w_state = S_ADDR;
            w_cnt   = '0;
          end
        end
        default: begin
          w_state = S_IDLE;
          w_cnt   = '0;
        end
      endcase
    end
  end

  always_comb begin
    w_axiov          = (w_state == S_ADDR) || (w_state == S_PIXEL) || (w_state == S_AUDIO);
    w_byte           = 8'h00;
    w_audio_ready    = 1'b0;
    w_audio_underrun = 1'b0;
    w_axiod          = 2'b00;
    w_shift          = 6'd0;

    // pixel_addr is frozen for the whole header, so it is the header source.
    case (w_state)
      S_ADDR: begin
        for (int j = 0; j < ADDR_BYTES; j++) begin
          if (w_cnt[c_cw-1:2] == c_hw'(j)) w_byte = pixel_addr[8*(ADDR_BYTES-1-j) +: 8];
        end
      end
      S_PIXEL: w_byte = pixel;
      S_AUDIO: begin
        if (w_cnt[1:0] == 2'd0) begin
          w_byte           = audio_valid ? audio : 8'h00;
          w_audio_ready    = audio_valid;
          w_audio_underrun = !audio_valid;
        end
      end
      default: w_byte = 8'h00;
    endcase

    if (w_axiov) begin
      if (w_cnt[1:0] == 2'd0) begin
        w_axiod = w_byte[1:0];
        w_shift = w_byte[7:2];
      end else begin
        w_axiod = r_shift[1:0];
        w_shift = {2'b00, r_shift[5:2]};
      end
    end

    if (AUDIO_BYTES > 0) w_pkt_done = (w_state == S_AUDIO) && (w_cnt == c_aud_last);
    else                 w_pkt_done = (w_state == S_PIXEL) && (w_cnt == c_pix_last);
  end

  always_comb begin
    w_unfinished = ((r_state == S_ADDR) || (r_state == S_PIXEL) || (r_state == S_AUDIO)) && !pkt_done;
    w_addr_inc   = (pixel_addr == c_aw'(FRAME_PIXELS - 1)) ? '0 : pixel_addr + 1'b1;
    w_pixel_addr = pixel_addr;
    w_pkt_start  = r_pkt_start;
    // An abort rewinds the read address so the whole packet is resent.
    if (stall) begin
      if (w_unfinished) w_pixel_addr = r_pkt_start;
    end else if ((w_state == S_PIXEL) && (w_cnt[1:0] == c_adv_phase)) begin
      w_pixel_addr = w_addr_inc;
    end
    if ((w_state == S_ADDR) && (r_state != S_ADDR)) w_pkt_start = pixel_addr;
  end

endmodule
`default_nettype wire

// File: tb/tb_pixel_packet_serializer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_pixel_packet_serializer                                               |
// | Three parameter sets run side by side against a packet-timeline model.   |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module tb_pixel_packet_serializer;

  logic clk;
  logic rst_n;
  logic stall;
  logic aud_directed;
  int   n_checks = 0;
  int   n_errors = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] abyte(input int inst, input int idx);
    return 8'((idx * 37 + inst * 91 + 11) & 255);
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_inst
    localparam int c_ab  = (g == 0) ? 3 : 4;
    localparam int c_p   = (g == 0) ? 320 : (g == 1) ? 37 : 50;
    localparam int c_au  = (g == 0) ? 4 : (g == 1) ? 2 : 0;
    localparam int c_fr  = (g == 0) ? 76800 : (g == 1) ? 1000 : 123;
    localparam int c_l   = (g == 0) ? 2 : (g == 1) ? 1 : 3;
    localparam int c_gap = (g == 0) ? 12 : (g == 1) ? 5 : 3;
    localparam int c_ltx = 4 * (c_ab + c_p + c_au);
    localparam int c_t   = c_ltx + c_gap;

    logic [7:0]        pixel, audio, bram_q1, bram_q2;
    logic              audio_valid, audio_ready, axiov, pkt_done, audio_underrun;
    logic [1:0]        axiod;
    logic [8*c_ab-1:0] pixel_addr;

    bit         m_active = 0, m_run = 0;
    int         m_pos = 0, m_aud_idx = 0, env_idx = 0;
    longint     m_start = 0, m_next = 0, e_addr = 0;
    logic [7:0] m_aud_byte = 8'h00;
    bit         e_v = 0, e_done = 0, e_rdy = 0, e_und = 0;
    logic [1:0] e_d = 2'b00;

    pixel_packet_serializer #(
      .ADDR_BYTES(c_ab), .PIXELS_PER_PKT(c_p), .AUDIO_BYTES(c_au),
      .FRAME_PIXELS(c_fr), .BRAM_LATENCY(c_l), .GAP_CYCLES(c_gap)
    ) u_dut (
      .clk(clk), .rst_n(rst_n), .stall(stall), .pixel(pixel), .audio(audio),
      .audio_valid(audio_valid), .audio_ready(audio_ready), .axiov(axiov),
      .axiod(axiod), .pixel_addr(pixel_addr), .pkt_done(pkt_done),
      .audio_underrun(audio_underrun)
    );

    // BRAM image: each location holds the low byte of its own address.
    always @(posedge clk) begin
      bram_q1 <= pixel_addr[7:0];
      bram_q2 <= bram_q1;
    end
    assign pixel = (c_l == 1) ? pixel_addr[7:0] : (c_l == 2) ? bram_q1 : bram_q2;
    assign audio = abyte(g, env_idx);

    // Audio source: valid only changes while no pop is pending.
    initial begin
      audio_valid = 1'b1;
      forever begin
        @(posedge clk);
        #1;
        if (g == 0 && aud_directed) audio_valid = !(m_active && (m_pos + 1 == 4 * (c_ab + c_p + 2)));
        else if (!audio_ready) audio_valid = ($urandom_range(0, 3) != 0);
      end
    end

    // Reference: position along the packet timeline (header, pixels, audio, gap).
    initial begin
      int b, k, i;
      logic [7:0] byte_v;
      forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
          m_active = 0; m_run = 0; m_pos = 0; m_start = 0; m_next = 0;
        end else if (!m_run) begin
          m_run = 1;
        end else if (stall) begin
          m_active = 0;
        end else if (!m_active) begin
          m_active = 1; m_pos = 0; m_start = m_next;
        end else begin
          m_pos++;
          if (m_pos == c_t) begin
            m_pos = 0; m_start = m_next;
          end
        end
        if (m_active && m_pos == c_ltx - 1) m_next = (m_start + c_p) % c_fr;

        e_v = 0; e_d = 2'b00; e_done = 0; e_rdy = 0; e_und = 0; e_addr = m_next;
        if (m_active && m_pos < c_ltx) begin
          b = m_pos / 4;
          k = m_pos % 4;
          if (b < c_ab) begin
            byte_v = 8'((m_start >> (8 * (c_ab - 1 - b))) & 255);
            e_addr = m_start;
          end else if (b < c_ab + c_p) begin
            i      = b - c_ab;
            byte_v = 8'(((m_start + i) % c_fr) & 255);
            e_addr = (k >= 4 - c_l) ? (m_start + i + 1) % c_fr : (m_start + i) % c_fr;
          end else begin
            e_addr = (m_start + c_p) % c_fr;
            if (k == 0) begin
              if (audio_valid) begin
                m_aud_byte = abyte(g, m_aud_idx);
                m_aud_idx++;
                e_rdy = 1;
              end else begin
                m_aud_byte = 8'h00;
                e_und = 1;
              end
            end
            byte_v = m_aud_byte;
          end
          e_v    = 1;
          e_d    = 2'((byte_v >> (2 * k)) & 3);
          e_done = (m_pos == c_ltx - 1);
        end
      end
    end

    initial begin
      forever begin
        @(negedge clk);
        check_value($sformatf("i%0d_axiov", g), axiov, e_v);
        check_value($sformatf("i%0d_axiod", g), axiod, e_d);
        check_value($sformatf("i%0d_pixel_addr", g), pixel_addr, e_addr);
        check_value($sformatf("i%0d_pkt_done", g), pkt_done, e_done);
        check_value($sformatf("i%0d_audio_ready", g), audio_ready, e_rdy);
        check_value($sformatf("i%0d_audio_underrun", g), audio_underrun, e_und);
        if (audio_ready && audio_valid) env_idx++;
      end
    end
  end

  task automatic wait_pkt(input longint start, input int pos, input int limit, input string tag);
    int n = 0;
    while (!(g_inst[0].m_active && g_inst[0].m_start == start && g_inst[0].m_pos == pos) && n < limit) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_value(tag, (n < limit), 1);
  endtask

  initial begin
    int rdy_cnt, und_cnt, done_cnt;
    rst_n        = 1'b0;
    stall        = 1'b0;
    aud_directed = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_value("rst_axiov", g_inst[0].axiov, 0);
    check_value("rst_axiod", g_inst[0].axiod, 0);
    check_value("rst_pixel_addr", g_inst[0].pixel_addr, 0);
    check_value("rst_audio_ready", g_inst[0].audio_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Abort at pixel slot 100 of the packet starting at 0x280.
    wait_pkt(640, 4 * (3 + 100) - 1, 6000, "reach_stall_point");
    stall = 1'b1;
    @(posedge clk);
    #1;
    check_value("stall_axiov", g_inst[0].axiov, 0);
    repeat (15) @(posedge clk);
    #1;
    check_value("stall_hold_addr", g_inst[0].pixel_addr, 640);
    check_value("stall_hold_pkt_done", g_inst[0].pkt_done, 0);
    stall        = 1'b0;
    aud_directed = 1'b1;

    // Resent packet with audio slot 2 starved.
    wait_pkt(640, 0, 10, "resend_start");
    check_value("resend_hdr_axiov", g_inst[0].axiov, 1);
    rdy_cnt = 0; und_cnt = 0; done_cnt = 0;
    for (int c = 0; c < 1308; c++) begin
      rdy_cnt  += int'(g_inst[0].audio_ready);
      und_cnt  += int'(g_inst[0].audio_underrun);
      done_cnt += int'(g_inst[0].pkt_done);
      @(posedge clk);
      #1;
    end
    check_value("dir_audio_ready_pulses", rdy_cnt, 3);
    check_value("dir_underrun_pulses", und_cnt, 1);
    check_value("dir_pkt_done_pulses", done_cnt, 1);
    aud_directed = 1'b0;

    // Asynchronous reset pulse between edges mid-PIXEL.
    wait_pkt(960, 600, 2000, "reach_reset_point");
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_value("arst_axiov", g_inst[0].axiov, 0);
    check_value("arst_axiod", g_inst[0].axiod, 0);
    check_value("arst_pixel_addr", g_inst[0].pixel_addr, 0);
    check_value("arst_pkt_done", g_inst[0].pkt_done, 0);
    check_value("arst_audio_ready", g_inst[0].audio_ready, 0);
    check_value("arst_underrun", g_inst[0].audio_underrun, 0);
    check_value("arst_i1_axiov", g_inst[1].axiov, 0);
    #1;
    rst_n = 1'b1;
    wait_pkt(0, 0, 10, "post_reset_start");
    check_value("post_reset_axiov", g_inst[0].axiov, 1);
    check_value("post_reset_addr", g_inst[0].pixel_addr, 0);

    repeat (1400) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
